// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and a single-word memory responder.
// master = initiator side, slave = responder side.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed access latency.
//
// state | meaning
// IDLE  | ready for a request (req_ready=1)
// WAIT  | request latched, latency down-counter running
// RESP  | access committed, response held until resp_ready
//
// The access (storage read or lane-masked write) happens on the edge that
// enters RESP, so a reset arriving before that edge discards the request
// with no effect on storage. Storage itself is never cleared by reset.
module mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_accept, w_commit;

    logic [31:0] r_addr, r_wdata;
    logic        r_wen;
    logic [3:0]  r_wstrb;

    logic [31:0] w_c_addr, w_c_wdata;
    logic        w_c_wen;
    logic [3:0]  w_c_wstrb;
    logic        w_fault;
    logic [AW-1:0] w_idx;

    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    // Commit operands: with LATENCY=1 the commit edge is the accept edge, so
    // the live request is used; otherwise the latched copy.
    always_comb begin
        if (r_state == IDLE) begin
            w_c_addr  = bus.req_addr;
            w_c_wen   = bus.req_wen;
            w_c_wdata = bus.req_wdata;
            w_c_wstrb = bus.req_wstrb;
        end else begin
            w_c_addr  = r_addr;
            w_c_wen   = r_wen;
            w_c_wdata = r_wdata;
            w_c_wstrb = r_wstrb;
        end
        w_fault = (w_c_addr < BASE_ADDR) || ({1'b0, w_c_addr} >= END_ADDR)
                  || (w_c_addr[1:0] != 2'b00);
        w_idx   = AW'((w_c_addr - BASE_ADDR) >> 2);
    end

    // Next-state, latency counter and accept/commit strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                        w_cnt_nxt   = 4'd0;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = 4'd0;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latch the request at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_wen   <= bus.req_wen;
            r_wdata <= bus.req_wdata;
            r_wstrb <= bus.req_wstrb;
        end
    end

    // Response registers: loaded at commit, zeroed when the response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_fault;
            r_rdata <= (w_fault || w_c_wen) ? 32'h0 : r_mem[w_idx];
        end else if ((r_state == RESP) && bus.resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

    // Lane-masked storage write at commit; reset blocks it and never clears storage.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_c_wen && !w_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (w_c_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 instance driven by directed
// and random traffic against a word-level reference model, plus a LATENCY=1
// instance exercised back to back.
module tb_mem_responder;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus1 ();

    mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] mdl [int];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          rr_mode    = 0;
    bit          in_resp    = 0;
    bit          hs_prev    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired, expected DUT event (cycle %0d)", name, cyc);
    endtask

    // Reference model: fault rules and lane merge computed on plain integers.
    function automatic exp_t model(input logic [31:0] addr, input logic wen,
                                   input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t   e;
        longint a    = {32'b0, addr};
        longint base = {32'b0, BASE};
        bit     flt  = (a < base) || (a >= base + 4 * DEPTH) || ((a % 4) != 0);
        int     w;
        logic [31:0] old;
        e.acc = 0;
        if (flt) begin
            e.rdata = 32'h0;
            e.err   = 1'b1;
        end else begin
            w = int'((a - base) / 4);
            e.err = 1'b0;
            if (wen) begin
                old = mdl.exists(w) ? mdl[w] : 32'h0;
                for (int i = 0; i < 4; i++)
                    if (wstrb[i]) old[8*i +: 8] = wdata[8*i +: 8];
                mdl[w]  = old;
                e.rdata = 32'h0;
            end else begin
                e.rdata = mdl[w];
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_wen   = wen;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        while (!bus.req_ready) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                fail_bound("accept_timeout");
                bus.req_valid = 1'b0;
                return;
            end
        end
        e     = model(addr, wen, wdata, wstrb);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wen   = 1'($urandom);
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.resp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_bound("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    // resp_ready is changed just after the rising edge so it is settled at the monitor.
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus.resp_ready = 1'b1;
            1:       bus.resp_ready = 1'($urandom_range(0, 1));
            default: bus.resp_ready = 1'b0;
        endcase
    end

    // Monitor: pops an expectation on each new response and checks it every cycle it is held.
    always @(negedge clk) begin
        if (rst) begin
            in_resp = 0;
            hs_prev = 0;
        end else begin
            if (hs_prev)
                chk("after_handshake", {62'b0, bus.resp_valid, bus.req_ready}, 64'b01);
            if (bus.resp_valid) begin
                if (!in_resp) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp: got a response, expected none (cycle %0d)", cyc);
                        cur.rdata = bus.resp_rdata;
                        cur.err   = bus.resp_err;
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", 64'(cyc + 1 - cur.acc), 64'(LAT));
                    end
                    in_resp = 1;
                end
                chk("resp_rdata", {32'b0, bus.resp_rdata}, {32'b0, cur.rdata});
                chk("resp_err", {63'b0, bus.resp_err}, {63'b0, cur.err});
                chk("req_ready_in_resp", {63'b0, bus.req_ready}, 64'd0);
                hs_prev = bus.resp_ready;
                if (bus.resp_ready) in_resp = 0;
            end else begin
                chk("idle_zero", {31'b0, bus.resp_err, bus.resp_rdata}, 64'd0);
                hs_prev = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int n;
        logic [31:0] a;
        int sel;
        bus.req_valid  = 1'b0; bus.req_addr  = '0; bus.req_wen  = 1'b0;
        bus.req_wdata  = '0;   bus.req_wstrb = '0; bus.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_wen = 1'b0;
        bus1.req_wdata = '0;   bus1.req_wstrb = '0; bus1.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        chk("rst_resp_data", {31'b0, bus.resp_err, bus.resp_rdata}, 64'd0);
        rst = 1'b0;
        chk("rst_req_ready", {63'b0, bus.req_ready}, 64'd1);
        chk("rst_req_ready_l1", {63'b0, bus1.req_ready}, 64'd1);

        for (int i = 0; i < 16; i++) issue(BASE + 32'(4 * i), 1'b1, 32'h0, 4'hF);

        issue(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
        issue(32'h8000_0010, 1'b0, 32'h0, 4'h0);
        issue(32'h8000_0010, 1'b1, 32'h0000_5500, 4'b0010);
        issue(32'h8000_0010, 1'b0, 32'h0, 4'h0);

        issue(32'h8000_0400, 1'b0, 32'h0, 4'h0);
        issue(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0);
        issue(32'h8000_0002, 1'b0, 32'h0, 4'h0);
        issue(32'h8000_0400, 1'b1, 32'h1111_1111, 4'hF);
        issue(32'h8000_0012, 1'b1, 32'h2222_2222, 4'hF);
        issue(32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0);
        issue(32'h8000_0010, 1'b0, 32'h0, 4'h0);
        issue(32'h8000_03FC, 1'b1, 32'hCAFE_F00D, 4'hF);
        issue(32'h8000_03FC, 1'b0, 32'h0, 4'h0);
        drain();

        rr_mode = 2;
        issue(32'h8000_0010, 1'b0, 32'h0, 4'h0);
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_bound("hold_wait_valid");
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = BASE + 32'(4 * $urandom_range(0, 15));
            bus.req_wen   = 1'($urandom);
            bus.req_wdata = $urandom;
            bus.req_wstrb = 4'hF;
            @(negedge clk);
            chk("hold_resp_valid", {63'b0, bus.resp_valid}, 64'd1);
        end
        bus.req_valid = 1'b0;
        rr_mode = 0;
        drain();
        repeat (3) begin
            @(negedge clk);
            chk("hold_no_extra", {63'b0, bus.resp_valid}, 64'd0);
        end

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0020;
        bus.req_wen   = 1'b1;
        bus.req_wdata = 32'h1234_5678;
        bus.req_wstrb = 4'hF;
        chk("rstabort_ready", {63'b0, bus.req_ready}, 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstabort_valid", {63'b0, bus.resp_valid}, 64'd0);
        chk("rstabort_req_ready", {63'b0, bus.req_ready}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rstabort_no_resp", {63'b0, bus.resp_valid}, 64'd0);
        end
        issue(32'h8000_0020, 1'b0, 32'h0, 4'h0);
        drain();

        rr_mode = 1;
        repeat (300) begin
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = BASE + 32'(4 * $urandom_range(0, 15));
            else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
            else               a = BASE - 32'(4 * $urandom_range(1, 100));
            issue(a, 1'($urandom), $urandom, 4'($urandom));
        end
        rr_mode = 0;
        drain();

        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.req_wen   = 1'b1;
        bus1.req_addr  = BASE + 32'd4;
        bus1.req_wdata = 32'hA5A5_0001;
        bus1.req_wstrb = 4'hF;
        chk("l1_ready", {63'b0, bus1.req_ready}, 64'd1);
        @(negedge clk);
        chk("l1_wr_resp", {30'b0, bus1.resp_valid, bus1.resp_err, bus1.resp_rdata},
            {30'b0, 2'b10, 32'h0});
        chk("l1_wr_req_ready", {63'b0, bus1.req_ready}, 64'd0);
        bus1.req_wen = 1'b0;
        @(negedge clk);
        chk("l1_idle", {62'b0, bus1.resp_valid, bus1.req_ready}, 64'b01);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("l1_rd_resp", {29'b0, bus1.resp_valid, bus1.req_ready, bus1.resp_err, bus1.resp_rdata},
                {29'b0, 3'b100, 32'hA5A5_0001});
            @(negedge clk);
            chk("l1_rd_gap", {62'b0, bus1.resp_valid, bus1.req_ready}, 64'b01);
        end
        bus1.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("l1_quiet", {63'b0, bus1.resp_valid}, 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
